imem_boot_loader: RTL

Writer side of the instruction-memory load path. Takes a UART-RX byte stream, assembles little-endian 32-bit words and writes them through the instruction-memory write port starting at `LOAD_BASE`, then releases the CPU. Sits between the UART receiver/transmitter and the instruction memory, replacing the software bootloader loop with a hardware engine.

---
 rtl/boot_pkg.sv | 25 ++
 rtl/boot_word_packer.sv | 73 +++++++
 rtl/imem_boot_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the hardware instruction-memory boot loader.
package boot_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEND_ACK,
      S_HDR,
      S_PAYLOAD,
      S_FLUSH,
      S_SEND_DONE,
      S_DONE,
      S_SEND_ERR,
      S_ERROR
   } boot_state_t;

   localparam logic [7:0] BOOT_ACK  = 8'h42;
   localparam logic [7:0] BOOT_DONE = 8'h44;
   localparam logic [7:0] BOOT_ERR  = 8'h45;

   // Byte enables for a word whose highest filled lane is 'lane'.
   function automatic logic [3:0] lane_mask(input logic [1:0] lane);
      return (4'b0010 << lane) - 4'b0001;
   endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs a little-endian byte stream into 32-bit words and issues one registered
// write per full word, or a partial write on flush.
module boot_word_packer
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   input  logic        flush_i,
   output logic [31:0] word_o,
   output logic [3:0]  be_o,
   output logic        wr_o,
   output logic        full_o
);

   logic [1:0]  lane_q, lane_d;
   logic [23:0] acc_q, acc_d;
   logic [31:0] word_q, word_d;
   logic [3:0]  be_q, be_d;
   logic        wr_q, wr_d;
   logic [31:0] merged;

   assign merged = {8'h00, acc_q} | ({24'h000000, byte_i} << {lane_q, 3'b000});
   assign full_o = byte_valid_i && (lane_q == 2'd3);

   // flush_i qualifies the current byte as the last one: it is written with the
   // partial word in the same registered write.
   always_comb begin
      lane_d = lane_q;
      acc_d  = acc_q;
      word_d = word_q;
      be_d   = be_q;
      wr_d   = 1'b0;
      if (clear_i) begin
         lane_d = 2'd0;
         acc_d  = 24'h0;
      end else if (byte_valid_i) begin
         if (full_o || flush_i) begin
            word_d = merged;
            be_d   = lane_mask(lane_q);
            wr_d   = 1'b1;
            lane_d = 2'd0;
            acc_d  = 24'h0;
         end else begin
            acc_d  = merged[23:0];
            lane_d = lane_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_q <= 2'd0;
         acc_q  <= 24'h0;
         word_q <= 32'h0;
         be_q   <= 4'h0;
         wr_q   <= 1'b0;
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
         word_q <= word_d;
         be_q   <= be_d;
         wr_q   <= wr_d;
      end
   end

   assign word_o = word_q;
   assign be_o   = be_q;
   assign wr_o   = wr_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Hardware boot loader: receives a length-prefixed image over UART, writes it
// into instruction memory from LOAD_BASE, reports status and releases the CPU.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_SEND_ACK| sending 'B'
// S_HDR     | receiving 4-byte little-endian length
// S_PAYLOAD | receiving payload bytes
// S_FLUSH   | partial last word being written
// S_SEND_DONE| sending 'D'
// S_DONE    | load complete, CPU released
// S_SEND_ERR| sending 'E'
// S_ERROR   | load failed
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter logic [31:0] LOAD_BASE      = 32'h0000_00C8,
   parameter int unsigned MAX_BYTES      = 32000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cpu_release
);

   localparam logic [31:0] TMO_RELOAD = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] MAX_LEN    = 32'(MAX_BYTES);

   boot_state_t state_q, state_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [31:0] len_q;
   logic [1:0]  hdr_cnt_q;
   logic [31:0] byte_cnt_q;
   logic [31:0] addr_q;
   logic [31:0] timer_q;

   logic        accept, in_rx, timeout, last_byte;
   logic [31:0] hdr_len;
   logic        pk_clear, pk_flush, pk_wr, pk_full;

   assign accept    = rx_valid && rx_ready;
   assign in_rx     = (state_q == S_HDR) || (state_q == S_PAYLOAD);
   assign timeout   = in_rx && !accept && (timer_q == 32'd0);
   assign hdr_len   = {rx_data, len_q[31:8]};
   assign last_byte = (byte_cnt_q + 32'd1) == len_q;

   always_comb begin
      state_d  = state_q;
      done_d   = done_q;
      error_d  = error_q;
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      pk_clear = 1'b0;
      pk_flush = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               done_d   = 1'b0;
               error_d  = 1'b0;
               pk_clear = 1'b1;
               state_d  = S_SEND_ACK;
            end
         end
         S_SEND_ACK: begin
            tx_valid = 1'b1;
            tx_data  = BOOT_ACK;
            if (tx_ready) state_d = S_HDR;
         end
         S_HDR: begin
            rx_ready = 1'b1;
            if (accept) begin
               if (hdr_cnt_q == 2'd3) begin
                  if (hdr_len == 32'd0)      state_d = S_SEND_DONE;
                  else if (hdr_len > MAX_LEN) state_d = S_SEND_ERR;
                  else                        state_d = S_PAYLOAD;
               end
            end else if (timeout) begin
               state_d = S_SEND_ERR;
            end
         end
         S_PAYLOAD: begin
            rx_ready = 1'b1;
            if (accept) begin
               if (last_byte) begin
                  pk_flush = 1'b1;
                  state_d  = pk_full ? S_SEND_DONE : S_FLUSH;
               end
            end else if (timeout) begin
               state_d = S_SEND_ERR;
            end
         end
         S_FLUSH: state_d = S_SEND_DONE;
         S_SEND_DONE: begin
            // Hold 'D' back while a completing full-word write is still on the
            // port so the status byte always trails the final write by a cycle.
            tx_data = BOOT_DONE;
            if (!pk_wr) begin
               tx_valid = 1'b1;
               if (tx_ready) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_SEND_ERR: begin
            tx_valid = 1'b1;
            tx_data  = BOOT_ERR;
            if (tx_ready) begin
               error_d = 1'b1;
               state_d = S_ERROR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q      <= 32'h0;
         hdr_cnt_q  <= 2'd0;
         byte_cnt_q <= 32'h0;
         addr_q     <= 32'h0;
         timer_q    <= 32'h0;
      end else begin
         if (state_q != S_HDR)  hdr_cnt_q <= 2'd0;
         else if (accept) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            len_q     <= hdr_len;
         end

         if (state_q != S_PAYLOAD) byte_cnt_q <= 32'h0;
         else if (accept)          byte_cnt_q <= byte_cnt_q + 32'd1;

         if (state_q == S_HDR && state_d == S_PAYLOAD) addr_q <= LOAD_BASE;
         else if (pk_wr)                               addr_q <= addr_q + 32'd4;

         if (!in_rx || accept)     timer_q <= TMO_RELOAD;
         else if (timer_q != 32'd0) timer_q <= timer_q - 32'd1;
      end
   end

   boot_word_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (pk_clear),
      .byte_valid_i (accept && (state_q == S_PAYLOAD)),
      .byte_i       (rx_data),
      .flush_i      (pk_flush),
      .word_o       (mem_wdata),
      .be_o         (mem_be),
      .wr_o         (pk_wr),
      .full_o       (pk_full)
   );

   assign mem_we      = pk_wr;
   assign mem_addr    = addr_q;
   assign busy        = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
   assign done        = done_q;
   assign error       = error_q;
   assign cpu_release = done_q;

endmodule
